// File: rtl/img_unloader.sv
// img_unloader: reads a 1-bit image RAM bit by bit, packs the bits LSB-first
// into bytes and hands each byte to a UART transmitter, pulsing done at the end.
module img_unloader #(
    parameter int NUM_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic              ram_q,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_rdy,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPT,
        SEND,
        GAP,
        FLUSH
    } state_t;

    // Bit index is one bit wider than the address so NUM_BITS=1024 cannot wrap.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_BITS - 1);
    localparam logic [ADDR_W:0] END_IDX  = (ADDR_W+1)'(NUM_BITS);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   bit_idx;
    logic [7:0]        byte_reg;
    logic [7:0]        byte_cap;
    logic              capt_last;
    logic              flush_first;

    // Byte value with the bit arriving this cycle merged in, and whether it closes the byte.
    always_comb begin
        byte_cap              = byte_reg;
        byte_cap[bit_idx[2:0]] = ram_q;
        capt_last             = (bit_idx[2:0] == 3'd7) || (bit_idx == LAST_IDX);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and state-derived outputs (address, handshake pulses, busy).
    always_comb begin
        state_nxt = state;
        ram_addr  = '0;
        tx_start  = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                // Only FETCH drives a real address, so it never exceeds NUM_BITS-1.
                ram_addr  = bit_idx[ADDR_W-1:0];
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = capt_last ? SEND : FETCH;
            end
            SEND: begin
                if (tx_rdy) begin
                    tx_start  = 1'b1;
                    state_nxt = (bit_idx == END_IDX) ? FLUSH : GAP;
                end
            end
            GAP: begin
                // tx_rdy may still read high right after tx_start; skip it.
                state_nxt = FETCH;
            end
            FLUSH: begin
                // First FLUSH cycle ignores tx_rdy for the same reason as GAP.
                if (!flush_first && tx_rdy) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: bit index, byte assembly, transmit holding register, flush guard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx     <= '0;
            byte_reg    <= '0;
            tx_data     <= '0;
            flush_first <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bit_idx  <= '0;
                    byte_reg <= '0;
                end
                CAPT: begin
                    byte_reg <= byte_cap;
                    bit_idx  <= bit_idx + 1'b1;
                    // tx_data changes only when a new byte enters SEND.
                    if (capt_last) begin
                        tx_data <= byte_cap;
                    end
                end
                SEND: begin
                    flush_first <= 1'b1;
                end
                GAP: begin
                    byte_reg <= '0;
                end
                FLUSH: begin
                    flush_first <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/img_unloader.md
IMG_UNLOADER -- requirements
Module: img_unloader

Interface
REQ-001 Parameter NUM_BITS, default 784, number of 1-bit RAM words dumped (addresses 0..NUM_BITS-1); legal range 1..1024.
REQ-002 Parameter ADDR_W, default 10, width of the RAM address.
REQ-003 clk  input  1  system clock; the block has one clock, and all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle pulse requesting a dump; sampled only in IDLE.
REQ-006 ram_addr  output  ADDR_W  read address to the 1-bit image RAM.
REQ-007 ram_q  input  1  RAM read data, valid exactly one cycle after ram_addr is presented.
REQ-008 tx_data  output  8  byte to the UART transmitter.
REQ-009 tx_start  output  1  single-cycle pulse that launches transmission of tx_data.
REQ-010 tx_rdy  input  1  transmitter idle, ready to accept a byte.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  single-cycle pulse when the dump is complete.

Function
REQ-013 FSM states: IDLE, FETCH, CAPT, SEND, GAP, FLUSH.
REQ-014 IDLE: ram_addr=0, bit index=0, byte register=0; start=1 -> FETCH next cycle; otherwise stay in IDLE.
REQ-015 FETCH: drive ram_addr = current bit index (zero-extended); -> CAPT.
REQ-016 CAPT: write ram_q into byte register bit position (bit index mod 8); increment bit index.
REQ-017 CAPT exit: if 8 bits are captured for this byte, or the bit index has reached NUM_BITS -> SEND; else -> FETCH.
REQ-018 Byte packing is LSB-first: RAM address 8k+j maps to bit j of byte k, which matches the loader's LSB-first bit order.
REQ-019 When NUM_BITS mod 8 != 0, the final byte SHALL carry the unfilled upper bits as 0.
REQ-020 SEND: hold tx_data = byte register; when tx_rdy=1, assert tx_start for exactly one cycle and leave SEND; while tx_rdy=0, stay in SEND with no tx_start.
REQ-021 After tx_start: -> GAP if bits remain; -> FLUSH after the final byte.
REQ-022 GAP: one cycle in which tx_rdy is ignored; clear the byte register; -> FETCH.
REQ-023 tx_data SHALL remain stable from tx_start until the next byte's SEND state is entered.
REQ-024 FLUSH: ignore tx_rdy in the first FLUSH cycle; afterwards, on tx_rdy=1, pulse done for one cycle and -> IDLE.
REQ-025 start asserted in any state other than IDLE SHALL be ignored and SHALL NOT restart or extend the dump.
REQ-026 Exactly ceil(NUM_BITS/8) tx_start pulses and exactly one done pulse SHALL occur per accepted start.
REQ-027 The bit index is ADDR_W+1 bits wide so that NUM_BITS=1024 does not wrap; ram_addr never exceeds NUM_BITS-1.
REQ-028 Each data bit costs 2 cycles (FETCH+CAPT); the start-to-first-tx_start minimum is 17 cycles when tx_rdy=1.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, ram_addr=0, tx_data=0, tx_start=0, busy=0, done=0, bit index=0, byte register=0.
REQ-030 Reset mid-dump abandons the transfer without a done pulse; the next accepted start restarts at address 0.

Verification
REQ-031 NUM_BITS=784, RAM bits 0 and 9 = 1, all others 0, tx_rdy tied 1 -> 98 tx_start pulses, bytes 0x01, 0x02, then 96 x 0x00, one done pulse.
REQ-032 At the first SEND, tx_rdy held 0 for 100 cycles -> no tx_start, tx_data stable at the byte value; single tx_start within 1 cycle of tx_rdy rising.
REQ-033 NUM_BITS=12, all RAM bits 1 -> bytes 0xFF, 0x0F, ram_addr never exceeds 11, done once.
REQ-034 Extra start pulses during busy -> still exactly 98 bytes and one done pulse.
REQ-035 rst_n low after byte 40 -> outputs zero while rst_n low, no done; new start -> first ram_addr=0, full 98-byte dump.
REQ-036 Transmitter model that drops tx_rdy 1 cycle after tx_start and stays busy for 10 bits -> no tx_start is ever issued while tx_rdy=0, and done follows the final byte's completion.
